// File: rtl/hazard_ctrl.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | hazard_ctrl : MW tracking, DE forward selects, load-use/memory-wait     |
// |               stalls and branch flush for the 3-stage pipeline.         |
// | Option     : HAZARD_PERF_CNT_EN adds saturating stall/flush counters.   |
// | Revision   : 1.0  initial release                                       |
// +-------------------------------------------------------------------------+
module hazard_ctrl #(
  parameter int REG_AW      = 5,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_de,
  input  logic [REG_AW-1:0] rs1_de,
  input  logic [REG_AW-1:0] rs2_de,
  input  logic [REG_AW-1:0] rd_de,
  input  logic              reg_wr_de,
  input  logic              mem_rd_de,
  input  logic              mem_wr_de,
  input  logic              br_taken_de,
  input  logic              dmem_ready,
  output logic              forward_ae,
  output logic              forward_be,
  output logic              stall_if,
  output logic              stall_de,
  output logic              bubble_mw,
  output logic              flush_fd,
  output logic              mem_timeout_err
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]       lu_stall_cnt,
  output logic [31:0]       mem_stall_cnt,
  output logic [31:0]       flush_cnt
`endif
);

  localparam logic [CNT_W-1:0] WAIT_MAX = CNT_W'(MEM_TIMEOUT);

  typedef enum logic [0:0] {
    ST_RUN      = 1'b0,
    ST_MEM_WAIT = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic                valid_mw_q, valid_mw_d;
  logic [REG_AW-1:0]   rd_mw_q, rd_mw_d;
  logic                reg_wr_mw_q, reg_wr_mw_d;
  logic                mem_rd_mw_q, mem_rd_mw_d;
  logic                mem_op_mw_q, mem_op_mw_d;
  logic [CNT_W-1:0]    wait_cnt_q, wait_cnt_d;
  logic                timeout_err_q, timeout_err_d;

  logic                mw_live;
  logic                hit_rs1;
  logic                hit_rs2;
  logic                mem_stall;
  logic                lu_stall;
  logic                any_stall;

  // x0 is hardwired zero, so a write to it never produces a forwardable value
  assign mw_live   = valid_mw_q & reg_wr_mw_q & (rd_mw_q != '0);
  assign hit_rs1   = mw_live & (rd_mw_q == rs1_de);
  assign hit_rs2   = mw_live & (rd_mw_q == rs2_de);

  // The first not-ready cycle already stalls, otherwise the access would leave MW
  assign mem_stall = valid_mw_q & mem_op_mw_q & ~dmem_ready;
  assign lu_stall  = valid_de & mem_rd_mw_q & (hit_rs1 | hit_rs2) & ~mem_stall;
  assign any_stall = mem_stall | lu_stall;

  assign forward_ae      = valid_de & hit_rs1 & ~mem_rd_mw_q;
  assign forward_be      = valid_de & hit_rs2 & ~mem_rd_mw_q;
  assign stall_if        = any_stall;
  assign stall_de        = any_stall;
  assign bubble_mw       = lu_stall;
  assign flush_fd        = valid_de & br_taken_de & ~any_stall;
  assign mem_timeout_err = timeout_err_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:      if (mem_stall) state_d = ST_MEM_WAIT;
      ST_MEM_WAIT: if (dmem_ready) state_d = ST_RUN;
      default:     state_d = ST_RUN;
    endcase
  end

  always_comb begin
    wait_cnt_d    = '0;
    timeout_err_d = timeout_err_q;
    if (mem_stall) begin
      wait_cnt_d = (wait_cnt_q == WAIT_MAX) ? wait_cnt_q : wait_cnt_q + CNT_W'(1);
      if (wait_cnt_d == WAIT_MAX) begin
        timeout_err_d = 1'b1;
      end
    end
  end

  always_comb begin
    valid_mw_d  = valid_mw_q;
    rd_mw_d     = rd_mw_q;
    reg_wr_mw_d = reg_wr_mw_q;
    mem_rd_mw_d = mem_rd_mw_q;
    mem_op_mw_d = mem_op_mw_q;
    if (!mem_stall) begin
      if (lu_stall) begin
        valid_mw_d  = 1'b0;
        rd_mw_d     = '0;
        reg_wr_mw_d = 1'b0;
        mem_rd_mw_d = 1'b0;
        mem_op_mw_d = 1'b0;
      end else begin
        valid_mw_d  = valid_de;
        rd_mw_d     = rd_de;
        reg_wr_mw_d = reg_wr_de;
        mem_rd_mw_d = mem_rd_de;
        mem_op_mw_d = mem_rd_de | mem_wr_de;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_RUN;
      valid_mw_q    <= 1'b0;
      rd_mw_q       <= '0;
      reg_wr_mw_q   <= 1'b0;
      mem_rd_mw_q   <= 1'b0;
      mem_op_mw_q   <= 1'b0;
      wait_cnt_q    <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      valid_mw_q    <= valid_mw_d;
      rd_mw_q       <= rd_mw_d;
      reg_wr_mw_q   <= reg_wr_mw_d;
      mem_rd_mw_q   <= mem_rd_mw_d;
      mem_op_mw_q   <= mem_op_mw_d;
      wait_cnt_q    <= wait_cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] lu_cnt_q, lu_cnt_d;
  logic [31:0] mem_cnt_q, mem_cnt_d;
  logic [31:0] fl_cnt_q, fl_cnt_d;

  always_comb begin
    lu_cnt_d  = lu_cnt_q;
    mem_cnt_d = mem_cnt_q;
    fl_cnt_d  = fl_cnt_q;
    if (lu_stall && (lu_cnt_q != '1))  lu_cnt_d  = lu_cnt_q + 32'd1;
    if (mem_stall && (mem_cnt_q != '1)) mem_cnt_d = mem_cnt_q + 32'd1;
    if (flush_fd && (fl_cnt_q != '1))  fl_cnt_d  = fl_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lu_cnt_q  <= '0;
      mem_cnt_q <= '0;
      fl_cnt_q  <= '0;
    end else begin
      lu_cnt_q  <= lu_cnt_d;
      mem_cnt_q <= mem_cnt_d;
      fl_cnt_q  <= fl_cnt_d;
    end
  end

  assign lu_stall_cnt  = lu_cnt_q;
  assign mem_stall_cnt = mem_cnt_q;
  assign flush_cnt     = fl_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | tb_hazard_ctrl : directed hazard scenarios followed by random traffic   |
// |                  compared against a behavioural pipeline model.         |
// | Revision       : 1.0  initial release                                   |
// +-------------------------------------------------------------------------+
module tb_hazard_ctrl;

  localparam int AW = 5;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          valid_de, reg_wr_de, mem_rd_de, mem_wr_de, br_taken_de, dmem_ready;
  logic [AW-1:0] rs1_de, rs2_de, rd_de;
  logic          forward_ae, forward_be, stall_if, stall_de, bubble_mw, flush_fd, mem_timeout_err;

  int errors = 0;
  int checks = 0;

  // Model of the instruction sitting in MW plus wait bookkeeping
  logic          m_v, m_wr, m_ld, m_mem, m_err;
  logic [AW-1:0] m_rd;
  int            m_waits;
  logic          e_pend, e_lu;

  hazard_ctrl #(.REG_AW(AW), .MEM_TIMEOUT(TO), .CNT_W(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .valid_de(valid_de), .rs1_de(rs1_de), .rs2_de(rs2_de), .rd_de(rd_de),
    .reg_wr_de(reg_wr_de), .mem_rd_de(mem_rd_de), .mem_wr_de(mem_wr_de),
    .br_taken_de(br_taken_de), .dmem_ready(dmem_ready),
    .forward_ae(forward_ae), .forward_be(forward_be),
    .stall_if(stall_if), .stall_de(stall_de), .bubble_mw(bubble_mw),
    .flush_fd(flush_fd), .mem_timeout_err(mem_timeout_err)
  );

  always #5 clk = ~clk;

  function automatic logic hit(input logic [AW-1:0] x);
    return m_v && m_wr && (m_rd != 0) && (m_rd == x);
  endfunction

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_v = 0; m_wr = 0; m_ld = 0; m_mem = 0; m_err = 0; m_rd = '0; m_waits = 0;
  endtask

  task automatic drive(input logic v, input logic [AW-1:0] r1, input logic [AW-1:0] r2,
                       input logic [AW-1:0] rd, input logic wr, input logic ld,
                       input logic st, input logic br, input logic rdy);
    valid_de = v; rs1_de = r1; rs2_de = r2; rd_de = rd;
    reg_wr_de = wr; mem_rd_de = ld; mem_wr_de = st; br_taken_de = br; dmem_ready = rdy;
    #1;
  endtask

  task automatic cmp_model();
    logic fa, fb, st;
    e_pend = m_v && m_mem && !dmem_ready;
    e_lu   = !e_pend && valid_de && m_ld && (hit(rs1_de) || hit(rs2_de));
    fa     = valid_de && hit(rs1_de) && !m_ld;
    fb     = valid_de && hit(rs2_de) && !m_ld;
    st     = e_pend || e_lu;
    chk("forward_ae", forward_ae, fa);
    chk("forward_be", forward_be, fb);
    chk("stall_if", stall_if, st);
    chk("stall_de", stall_de, st);
    chk("bubble_mw", bubble_mw, e_lu);
    chk("flush_fd", flush_fd, valid_de && br_taken_de && !st);
    chk("mem_timeout_err", mem_timeout_err, m_err);
  endtask

  task automatic advance();
    @(posedge clk);
    if (e_pend) begin
      if (m_waits < TO) m_waits++;
      if (m_waits >= TO) m_err = 1;
    end else begin
      m_waits = 0;
      if (e_lu) begin
        m_v = 0; m_wr = 0; m_ld = 0; m_mem = 0;
      end else begin
        m_v = valid_de; m_rd = rd_de; m_wr = reg_wr_de;
        m_ld = mem_rd_de; m_mem = mem_rd_de || mem_wr_de;
      end
    end
    #1;
  endtask

  initial begin
    rst_n = 0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    m_reset();
    @(posedge clk); @(posedge clk); #1;
    cmp_model();
    chk("reset_stall", stall_de, 1'b0);
    rst_n = 1;

    // ALU forwarding: addi x5 ; add x6,x5,x5
    drive(1, 0, 0, 5, 1, 0, 0, 0, 1); cmp_model(); advance();
    drive(1, 5, 5, 6, 1, 0, 0, 0, 1); cmp_model();
    chk("alu_fwd_a", forward_ae, 1'b1);
    chk("alu_fwd_b", forward_be, 1'b1);
    chk("alu_fwd_nostall", stall_de, 1'b0);
    advance();
    // Destination x0 never forwards
    drive(1, 0, 0, 0, 1, 0, 0, 0, 1); cmp_model(); advance();
    drive(1, 0, 0, 6, 1, 0, 0, 0, 1); cmp_model();
    chk("x0_fwd_a", forward_ae, 1'b0);
    chk("x0_fwd_b", forward_be, 1'b0);
    advance();

    // Load-use: lw x7 ; add x8,x7,x1
    drive(1, 1, 0, 7, 1, 1, 0, 0, 1); cmp_model(); advance();
    drive(1, 7, 1, 8, 1, 0, 0, 0, 1); cmp_model();
    chk("lu_stall_if", stall_if, 1'b1);
    chk("lu_bubble", bubble_mw, 1'b1);
    advance();
    cmp_model();
    chk("lu_released", stall_de, 1'b0);
    chk("lu_no_fwd", forward_ae, 1'b0);
    advance();
    // Load followed by an unrelated reader
    drive(1, 1, 0, 7, 1, 1, 0, 0, 1); cmp_model(); advance();
    drive(1, 9, 1, 8, 1, 0, 0, 0, 1); cmp_model();
    chk("lu_unrelated", stall_de, 1'b0);
    advance();

    // Memory wait of three cycles
    drive(1, 1, 0, 7, 1, 1, 0, 0, 1); cmp_model(); advance();
    for (int i = 0; i < 3; i++) begin
      drive(1, 9, 2, 4, 1, 0, 0, 0, 0); cmp_model();
      chk("wait_stall", stall_if, 1'b1);
      chk("wait_nobubble", bubble_mw, 1'b0);
      advance();
    end
    drive(1, 9, 2, 4, 1, 0, 0, 0, 1); cmp_model();
    chk("wait_done", stall_if, 1'b0);
    advance();
    // Zero-wait store
    drive(1, 1, 2, 0, 0, 0, 1, 0, 1); cmp_model(); advance();
    drive(1, 9, 2, 4, 1, 0, 0, 0, 1); cmp_model();
    chk("zero_wait", stall_de, 1'b0);
    advance();

    // Branch held off by a load-use stall, then released
    drive(1, 1, 0, 7, 1, 1, 0, 0, 1); cmp_model(); advance();
    drive(1, 7, 0, 0, 0, 0, 0, 1, 1); cmp_model();
    chk("br_under_stall", flush_fd, 1'b0);
    advance();
    cmp_model();
    chk("br_after_stall", flush_fd, 1'b1);
    advance();
    drive(1, 0, 0, 0, 0, 0, 0, 1, 1); cmp_model();
    chk("br_plain", flush_fd, 1'b1);
    advance();

    // Timeout: six not-ready cycles against a limit of four
    drive(1, 1, 0, 7, 1, 1, 0, 0, 1); cmp_model(); advance();
    for (int i = 0; i < 6; i++) begin
      drive(1, 9, 2, 4, 1, 0, 0, 0, 0); cmp_model();
      chk("timeout_level", mem_timeout_err, (i >= 4) ? 1'b1 : 1'b0);
      advance();
    end
    drive(1, 9, 2, 4, 1, 0, 0, 0, 1); cmp_model();
    chk("timeout_sticky", mem_timeout_err, 1'b1);
    advance();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1); cmp_model();
    chk("timeout_sticky2", mem_timeout_err, 1'b1);
    advance();

    // Asynchronous reset in the middle of a memory wait
    drive(1, 1, 0, 7, 1, 1, 0, 0, 1); cmp_model(); advance();
    drive(1, 9, 2, 4, 1, 0, 0, 0, 0); cmp_model(); advance();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 0; #1;
    m_reset();
    cmp_model();
    chk("rst_mid_stall", stall_if, 1'b0);
    chk("rst_mid_err", mem_timeout_err, 1'b0);
    @(posedge clk); #1;
    rst_n = 1;
    drive(1, 7, 7, 3, 1, 0, 0, 0, 1); cmp_model();
    chk("rst_fwd_a", forward_ae, 1'b0);
    chk("rst_fwd_b", forward_be, 1'b0);
    chk("rst_nostall", stall_de, 1'b0);
    advance();

    // Random traffic on a small register window to provoke hazards
    for (int n = 0; n < 600; n++) begin
      logic ld, st;
      if ((n % 200) == 199) begin
        rst_n = 0; #1; m_reset();
        @(posedge clk); #1; rst_n = 1;
      end
      ld = ($urandom_range(0, 2) == 0);
      st = !ld && ($urandom_range(0, 3) == 0);
      drive($urandom_range(0, 3) != 0,
            AW'($urandom_range(0, 3)), AW'($urandom_range(0, 3)), AW'($urandom_range(0, 3)),
            ld || (!st && ($urandom_range(0, 3) != 0)), ld, st,
            $urandom_range(0, 5) == 0, $urandom_range(0, 3) != 0);
      cmp_model();
      advance();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
